uart_tx_queue: RTL and testbench
================================

# uart_tx_queue

Byte queue and start sequencer that sits directly upstream of the UART transmitter. The core writes bytes into a small synchronous FIFO at full clock rate. The block drains the FIFO one byte at a time by pulsing `tx_start` with `sdata` valid and then waiting for the transmitter's `tx_busy` to rise and fall. The core can therefore issue back-to-back output writes without polling the serial line.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2**DEPTH_LOG2 entries (16).
- `clk`  in  1  system clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `wr_en`  in  1  push strobe; one byte per cycle.
- `wr_data`  in  8  byte to push.
- `full`  out  1  FIFO holds 2**DEPTH_LOG2 entries.
- `empty`  out  1  FIFO holds 0 entries.
- `count`  out  DEPTH_LOG2+1  current occupancy.
- `sdata`  out  8  byte presented to the transmitter.
- `tx_start`  out  1  one-cycle start pulse to the transmitter.
- `tx_busy`  in  1  transmitter busy flag; registered, rises the cycle after `tx_start`.
- `ovf`  out  1  sticky overflow flag (only with `UART_TXQ_OVF_EN`).
- `ovf_clr`  in  1  clears `ovf` (only with `UART_TXQ_OVF_EN`).

## Operation
- **FIFO**
  - Circular buffer with read and write pointers of DEPTH_LOG2 bits, wrapping modulo depth.
  - `count` is DEPTH_LOG2+1 bits, so full = `count == 2**DEPTH_LOG2`.
  - Push happens when `wr_en && !full`. `wr_en` while `full` drops the byte and leaves pointers and contents untouched, even if a pop occurs on the same edge.
  - Push and pop on the same edge: both pointers advance and `count` is unchanged.
- **Sequencer FSM**, states IDLE, START, WAIT_HI, WAIT_LO:
  - IDLE: if `!empty && !tx_busy`, register `sdata <= head byte`, `tx_start <= 1`, pop the head, and go to START.
  - START: `tx_start <= 0`, go to WAIT_HI. `sdata` holds its value.
  - WAIT_HI: stay until `tx_busy == 1`, then go to WAIT_LO.
  - WAIT_LO: stay until `tx_busy == 0`, then go to IDLE.
- `tx_start` is never high in two consecutive cycles.
- `sdata` is only changed in IDLE.
- Reset (`rstn == 0` at an edge), including mid-operation:
  - FSM goes to IDLE and both pointers go to 0.
  - Outputs: `count = 0`, `empty = 1`, `full = 0`, `tx_start = 0`, `sdata = 0`, `ovf = 0`.
  - FIFO contents are not cleared; they are unobservable because the FIFO is empty.

## Timing
- All outputs are registered.
- Write to empty queue, transmitter idle: `wr_en` sampled at edge 0, `empty` falls after edge 0, `tx_start` is high after edge 1. Latency is 2 cycles.
- `tx_start` pulse → `tx_busy` rises one cycle later → WAIT_HI exits on that cycle.
- `tx_busy` falls at cycle t → FSM is IDLE after edge t, and the next `tx_start` is high after edge t+1. Minimum gap is one idle cycle between frames.
- `count` and `full` reflect a push or pop on the edge after it.
- A pop in IDLE updates `empty` on the same edge that raises `tx_start`.

## Configuration
- Feature macro: `UART_TXQ_OVF_EN`.
- **Defined:**
  - Ports `ovf` and `ovf_clr` exist.
  - `ovf` is set on any edge with `wr_en && full`.
  - `ovf_clr` clears it on the next edge.
  - If set and clear occur together, set wins.
- **Undefined:** the ports are absent and overflow writes are dropped silently.
- All other behaviour is identical in both builds.

## Structure
- Package `uart_pkg` holds:
  - the `txq_state_t` enum {IDLE, START, WAIT_HI, WAIT_LO};
  - the localparam `TXQ_DEPTH_LOG2_DEFAULT = 4`.
- Sub-module `byte_fifo` (parameter DEPTH_LOG2) implements storage, pointers, `count`, `full` and `empty`, and exposes a `pop` input and a `head` output.
- Top level holds the FSM and the optional overflow logic.

## Test plan
- Reset, then one write of 0x55 with the transmitter idle → `tx_start` high exactly 2 cycles later for 1 cycle, `sdata = 0x55`, `empty = 1` afterwards.
- Burst of 3 writes 0x01, 0x02, 0x03 on consecutive cycles, with a transmitter model whose `tx_busy` stays high for 20 cycles per frame → 3 `tx_start` pulses in order 0x01, 0x02, 0x03, each exactly 2 cycles after the preceding `tx_busy` fall.
- 17 writes with the transmitter held busy (DEPTH_LOG2 = 4) → `count` saturates at 16 with `full = 1`, the 17th byte is dropped, and `ovf = 1` with the macro defined. After drain, exactly 16 bytes are observed in order.
- Simultaneous push and pop at `count = 5` → `count` stays 5 and the byte order is preserved across pointer wrap-around (drive 40 bytes through the queue).
- `rstn` asserted while in WAIT_LO with `count = 3` → after the edge `count = 0`, `tx_start = 0`, and the FSM is IDLE. No `tx_start` occurs until a new write.
- With the macro defined, `ovf_clr` pulsed in the same cycle as an overflow write → `ovf` remains 1. A later lone `ovf_clr` → `ovf = 0`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit byte queue.
package uart_pkg;

    localparam int unsigned TXQ_DEPTH_LOG2_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_HI,
        WAIT_LO
    } txq_state_t;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Core-side write port and transmitter-side start handshake of the UART transmit queue.
// The ovf/ovf_clr pair exists only when UART_TXQ_OVF_EN is defined.
interface uart_tx_queue_if
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = TXQ_DEPTH_LOG2_DEFAULT
);

    logic                wr_en;
    logic [7:0]          wr_data;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] count;
    logic [7:0]          sdata;
    logic                tx_start;
    logic                tx_busy;
`ifdef UART_TXQ_OVF_EN
    logic                ovf;
    logic                ovf_clr;

    modport master (
        output wr_en, wr_data, tx_busy, ovf_clr,
        input  full, empty, count, sdata, tx_start, ovf
    );

    modport slave (
        input  wr_en, wr_data, tx_busy, ovf_clr,
        output full, empty, count, sdata, tx_start, ovf
    );
`else
    modport master (
        output wr_en, wr_data, tx_busy,
        input  full, empty, count, sdata, tx_start
    );

    modport slave (
        input  wr_en, wr_data, tx_busy,
        output full, empty, count, sdata, tx_start
    );
`endif

endinterface

// File: rtl/byte_fifo.sv
// Circular byte buffer with occupancy count; pushes into a full buffer are dropped.
module byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = TXQ_DEPTH_LOG2_DEFAULT
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                push,
    input  logic [7:0]          wr_data,
    input  logic                pop,
    output logic [7:0]          head,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_q, wr_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  do_push, do_pop;

    // A drop-on-full push must not disturb state even if a pop frees a slot this edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            if (do_push && !do_pop) begin
                count_q <= count_q + (DEPTH_LOG2 + 1)'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - (DEPTH_LOG2 + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && do_push) mem[wr_ptr_q] <= wr_data;
    end

    assign head  = mem[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding the UART transmitter: drains one byte per tx_start/tx_busy frame.
// Optional sticky overflow flag enabled by UART_TXQ_OVF_EN.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = TXQ_DEPTH_LOG2_DEFAULT
) (
    input logic              clk,
    input logic              rstn,
    uart_tx_queue_if.slave   bus
);

    txq_state_t          state_q, state_d;
    logic [7:0]          sdata_q, sdata_d;
    logic                tx_start_q, tx_start_d;
    logic                pop;
    logic [7:0]          head;
    logic                fifo_full, fifo_empty;
    logic [DEPTH_LOG2:0] fifo_count;

    byte_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push    (bus.wr_en),
        .wr_data (bus.wr_data),
        .pop     (pop),
        .head    (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            sdata_q    <= 8'h00;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sdata_q    <= sdata_d;
            tx_start_q <= tx_start_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sdata_d    = sdata_q;
        tx_start_d = 1'b0;
        pop        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && !bus.tx_busy) begin
                    sdata_d    = head;
                    tx_start_d = 1'b1;
                    pop        = 1'b1;
                    state_d    = START;
                end
            end
            START:   state_d = WAIT_HI;
            WAIT_HI: if (bus.tx_busy)  state_d = WAIT_LO;
            WAIT_LO: if (!bus.tx_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.sdata    = sdata_q;
    assign bus.tx_start = tx_start_q;
    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.count    = fifo_count;

`ifdef UART_TXQ_OVF_EN
    logic ovf_q;

    // Set has priority so an overflow coinciding with a clear is never lost.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ovf_q <= 1'b0;
        end else if (bus.wr_en && fifo_full) begin
            ovf_q <= 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a simple transmitter busy model.
// Overflow checks are compiled in when UART_TXQ_OVF_EN is defined.
module tb_uart_tx_queue;
    import uart_pkg::*;

    localparam int unsigned DL = TXQ_DEPTH_LOG2_DEFAULT;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    uart_tx_queue_if #(.DEPTH_LOG2(DL)) bus ();

    uart_tx_queue #(.DEPTH_LOG2(DL)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Transmitter model: busy rises the cycle after tx_start and lasts busy_len cycles.
    int   busy_len   = 20;
    int   busy_cnt   = 0;
    logic force_busy = 1'b0;
    int   cyc        = 0;

    assign bus.tx_busy = force_busy || (busy_cnt != 0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.tx_start) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    logic [7:0] got_q[$];
    int         start_cyc_q[$];
    int         fall_cyc_q[$];
    logic       prev_busy = 1'b0;

    always @(negedge clk) begin
        if (bus.tx_start) begin
            got_q.push_back(bus.sdata);
            start_cyc_q.push_back(cyc);
        end
        if (prev_busy && !bus.tx_busy) fall_cyc_q.push_back(cyc);
        prev_busy = bus.tx_busy;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_starts(input int n, input int limit);
        int quiet = 0;
        for (int i = 0; i < limit; i++) begin
            if (got_q.size() >= n && quiet >= 3) break;
            tick();
            quiet = (bus.tx_busy || bus.tx_start) ? 0 : quiet + 1;
        end
        chk("start_count", got_q.size(), n);
    endtask

    task automatic clear_logs();
        got_q.delete();
        start_cyc_q.delete();
        fall_cyc_q.delete();
    endtask

    initial begin
        int nxt;
        rstn        = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
`ifdef UART_TXQ_OVF_EN
        bus.ovf_clr = 1'b0;
`endif
        repeat (3) tick();

        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_tx_start", bus.tx_start, 0);
        chk("rst_sdata", bus.sdata, 0);
`ifdef UART_TXQ_OVF_EN
        chk("rst_ovf", bus.ovf, 0);
`endif
        rstn = 1'b1;
        tick();

        // Single write: tx_start two cycles after wr_en is presented.
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h55;
        tick();
        bus.wr_en = 1'b0;
        chk("single_empty_e0", bus.empty, 0);
        chk("single_count_e0", bus.count, 1);
        chk("single_start_e0", bus.tx_start, 0);
        tick();
        chk("single_start_e1", bus.tx_start, 1);
        chk("single_sdata_e1", bus.sdata, 8'h55);
        chk("single_empty_e1", bus.empty, 1);
        tick();
        chk("single_start_e2", bus.tx_start, 0);
        chk("single_sdata_hold", bus.sdata, 8'h55);
        wait_starts(1, 100);

        // Burst of three with 20-cycle frames.
        clear_logs();
        for (int i = 1; i <= 3; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(i);
            tick();
        end
        bus.wr_en = 1'b0;
        wait_starts(3, 300);
        for (int i = 0; i < 3; i++) chk("burst_byte", got_q[i], 32'(i + 1));
        chk("burst_gap1", start_cyc_q[1] - fall_cyc_q[0], 2);
        chk("burst_gap2", start_cyc_q[2] - fall_cyc_q[1], 2);

        // Fill to full with the transmitter held busy, then overflow.
        busy_len   = 4;
        force_busy = 1'b1;
        clear_logs();
        for (int i = 0; i < 16; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(8'h10 + i);
            tick();
        end
        chk("fill_count16", bus.count, 16);
        chk("fill_full", bus.full, 1);
`ifdef UART_TXQ_OVF_EN
        chk("fill_ovf_pre", bus.ovf, 0);
        bus.ovf_clr = 1'b1;
`endif
        bus.wr_data = 8'hEE;
        tick();
        bus.wr_en = 1'b0;
`ifdef UART_TXQ_OVF_EN
        bus.ovf_clr = 1'b0;
`endif
        chk("ovfw_count", bus.count, 16);
        chk("ovfw_full", bus.full, 1);
`ifdef UART_TXQ_OVF_EN
        chk("ovf_set_wins", bus.ovf, 1);
        tick();
        chk("ovf_sticky", bus.ovf, 1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("ovf_cleared", bus.ovf, 0);
`endif
        force_busy = 1'b0;
        wait_starts(16, 400);
        for (int i = 0; i < 16; i++) chk("drain_byte", got_q[i], 32'(8'h10 + i));

        // Simultaneous push/pop at count 5, then stream 40 bytes across the wrap.
        force_busy = 1'b1;
        clear_logs();
        for (int i = 0; i < 5; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(i);
            tick();
        end
        chk("pp_count_pre", bus.count, 5);
        force_busy  = 1'b0;
        bus.wr_data = 8'd5;
        tick();
        bus.wr_en = 1'b0;
        chk("pp_count_same", bus.count, 5);
        chk("pp_tx_start", bus.tx_start, 1);
        chk("pp_sdata", bus.sdata, 0);
        nxt = 6;
        for (int i = 0; i < 2000 && nxt < 40; i++) begin
            if (!bus.full) begin
                bus.wr_en   = 1'b1;
                bus.wr_data = 8'(nxt);
                nxt++;
            end else begin
                bus.wr_en = 1'b0;
            end
            tick();
        end
        bus.wr_en = 1'b0;
        wait_starts(40, 800);
        for (int i = 0; i < 40; i++) chk("wrap_byte", got_q[i], 32'(i));

        // Reset while in WAIT_LO with three bytes queued.
        busy_len = 20;
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(8'hC1 + i);
            tick();
        end
        bus.wr_en = 1'b0;
        chk("midrst_count_pre", bus.count, 3);
        chk("midrst_busy_pre", bus.tx_busy, 1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("midrst_count", bus.count, 0);
        chk("midrst_empty", bus.empty, 1);
        chk("midrst_tx_start", bus.tx_start, 0);
        chk("midrst_sdata", bus.sdata, 0);
        repeat (60) tick();
        chk("midrst_no_start", got_q.size(), 1);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hA5;
        tick();
        bus.wr_en = 1'b0;
        wait_starts(2, 100);
        chk("midrst_new_byte", got_q[1], 8'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
